// File: rtl/bus_cycle.sv
// bus_cycle: arbitrated system-bus cycle engine between the P-X state-control unit and the bus; ports: __clk/clo_n, CPU side (zg,w,r,ad,dt_o,nb,q -> zw1,rok,ren,rpe,talarm,dt_i), bus side (bus_rq/bus_gnt, bus_ad/dt_o/nb/qb/w/r, bus_ok/en/pe/dt_i)
module bus_cycle #(
  parameter int TIMEOUT = 250,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          __clk,
  input  logic          clo_n,
  input  logic          zg,
  input  logic          w,
  input  logic          r,
  input  logic [AW-1:0] ad,
  input  logic [DW-1:0] dt_o,
  input  logic [3:0]    nb,
  input  logic          q,
  output logic          zw1,
  output logic          rok,
  output logic          ren,
  output logic          rpe,
  output logic          talarm,
  output logic [DW-1:0] dt_i,
  output logic          bus_rq,
  input  logic          bus_gnt,
  output logic [AW-1:0] bus_ad,
  output logic [DW-1:0] bus_dt_o,
  output logic [3:0]    bus_nb,
  output logic          bus_qb,
  output logic          bus_w,
  output logic          bus_r,
  input  logic          bus_ok,
  input  logic          bus_en,
  input  logic          bus_pe,
  input  logic [DW-1:0] bus_dt_i
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, REQ, ADDR, STRB, DONE, REL} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic lw, lr;
  logic pe_hit, timed_out, finish;
  // parity error only means something on a read; on a write it is ignored
  assign pe_hit = lr & bus_pe;
  assign timed_out = timer == TW'(TIMEOUT - 1);
  assign finish = pe_hit | bus_en | bus_ok | timed_out;
  always_ff @(posedge __clk or negedge clo_n) begin
    if (!clo_n) begin
      state <= IDLE;
      timer <= '0;
      lw <= 1'b0;
      lr <= 1'b0;
      zw1 <= 1'b0;
      rok <= 1'b0;
      ren <= 1'b0;
      rpe <= 1'b0;
      talarm <= 1'b0;
      dt_i <= '0;
      bus_rq <= 1'b0;
      bus_ad <= '0;
      bus_dt_o <= '0;
      bus_nb <= '0;
      bus_qb <= 1'b0;
      bus_w <= 1'b0;
      bus_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (zg) begin
          state <= REQ;
          bus_rq <= 1'b1;
        end
        REQ: if (!zg) begin
          state <= IDLE;
          bus_rq <= 1'b0;
        end else if (bus_gnt) begin
          state <= ADDR;
          zw1 <= 1'b1;
          lw <= w;
          lr <= r;
          bus_ad <= ad;
          bus_dt_o <= (w & ~r) ? dt_o : '0;
          bus_nb <= nb;
          bus_qb <= q;
        end
        ADDR: if (lr ^ lw) begin
          state <= STRB;
          bus_w <= lw;
          bus_r <= lr;
          timer <= '0;
        end else begin
          state <= DONE;
          talarm <= 1'b1;
        end
        STRB: if (finish) begin
          state <= DONE;
          bus_w <= 1'b0;
          bus_r <= 1'b0;
          rpe <= pe_hit;
          ren <= ~pe_hit & bus_en;
          rok <= ~pe_hit & ~bus_en & bus_ok;
          talarm <= ~pe_hit & ~bus_en & ~bus_ok;
          if (lr && (pe_hit || (!bus_en && bus_ok))) dt_i <= bus_dt_i;
        end else begin
          timer <= (timer == '1) ? timer : timer + 1'b1;
        end
        DONE: if (!zg) begin
          state <= REL;
          rok <= 1'b0;
          ren <= 1'b0;
          rpe <= 1'b0;
          talarm <= 1'b0;
        end
        REL: if (!(bus_ok | bus_en | bus_pe)) begin
          state <= IDLE;
          bus_rq <= 1'b0;
          zw1 <= 1'b0;
          bus_ad <= '0;
          bus_dt_o <= '0;
          bus_nb <= '0;
          bus_qb <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_cycle.sv
// tb_bus_cycle: directed self-checking bench for bus_cycle
module tb_bus_cycle;
  logic clk = 1'b0, clo_n = 1'b0;
  logic zg = 0, w = 0, r = 0, q = 0, bus_gnt = 0, bus_ok = 0, bus_en = 0, bus_pe = 0;
  logic [15:0] ad = 0, dt_o = 0, bus_dt_i = 0;
  logic [3:0] nb = 0;
  logic zw1, rok, ren, rpe, talarm, bus_rq, bus_qb, bus_w, bus_r;
  logic [15:0] dt_i, bus_ad, bus_dt_o;
  logic [3:0] bus_nb;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  bus_cycle dut (
    .__clk(clk), .clo_n(clo_n), .zg(zg), .w(w), .r(r), .ad(ad), .dt_o(dt_o), .nb(nb), .q(q),
    .zw1(zw1), .rok(rok), .ren(ren), .rpe(rpe), .talarm(talarm), .dt_i(dt_i),
    .bus_rq(bus_rq), .bus_gnt(bus_gnt), .bus_ad(bus_ad), .bus_dt_o(bus_dt_o), .bus_nb(bus_nb),
    .bus_qb(bus_qb), .bus_w(bus_w), .bus_r(bus_r), .bus_ok(bus_ok), .bus_en(bus_en),
    .bus_pe(bus_pe), .bus_dt_i(bus_dt_i)
  );
  task automatic release_cycle;
    zg = 0; bus_ok = 0; bus_en = 0; bus_pe = 0; w = 0; r = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({zw1, rok, ren, rpe, talarm, bus_rq, bus_w, bus_r, bus_qb, bus_nb, dt_i, bus_ad, bus_dt_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got zw1=%b rok=%b ren=%b rpe=%b tal=%b rq=%b w=%b r=%b dt_i=%h ad=%h, want all 0",
               zw1, rok, ren, rpe, talarm, bus_rq, bus_w, bus_r, dt_i, bus_ad);
    end
    clo_n = 1;
    @(negedge clk);
  endtask
  task automatic test_read_ok;
    bus_gnt = 1; zg = 1; r = 1; ad = 16'h1234; nb = 4'h9; q = 1;
    @(negedge clk);
    checks++;
    if ({bus_rq, zw1} !== 2'b10) begin failures++; $display("FAIL rd_lat1: rq,zw1=%b want 10", {bus_rq, zw1}); end
    @(negedge clk);
    checks++;
    if ({zw1, bus_r, bus_ad, bus_nb, bus_qb} !== {2'b10, 16'h1234, 4'h9, 1'b1})
      begin failures++; $display("FAIL rd_addr: zw1=%b r=%b ad=%h nb=%h qb=%b want 1 0 1234 9 1", zw1, bus_r, bus_ad, bus_nb, bus_qb); end
    @(negedge clk);
    checks++;
    if ({bus_r, bus_w, bus_dt_o} !== {2'b10, 16'h0}) begin failures++; $display("FAIL rd_strobe: r=%b w=%b dto=%h want 1 0 0000", bus_r, bus_w, bus_dt_o); end
    @(negedge clk);
    bus_ok = 1; bus_dt_i = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({rok, ren, rpe, talarm, bus_r, dt_i} !== {5'b10000, 16'hBEEF})
      begin failures++; $display("FAIL rd_ok: rok=%b ren=%b rpe=%b tal=%b r=%b dt_i=%h want 1 0 0 0 0 beef", rok, ren, rpe, talarm, bus_r, dt_i); end
    bus_ok = 0; bus_dt_i = 16'h0; zg = 0;
    @(negedge clk);
    checks++;
    if ({rok, zw1} !== 2'b01) begin failures++; $display("FAIL rd_drop: rok=%b zw1=%b want 0 1", rok, zw1); end
    @(negedge clk);
    checks++;
    if ({zw1, bus_rq, bus_ad, dt_i} !== {18'h0, 16'hBEEF}) begin failures++; $display("FAIL rd_idle: zw1=%b rq=%b ad=%h dt_i=%h want 0 0 0000 beef", zw1, bus_rq, bus_ad, dt_i); end
    release_cycle();
  endtask
  task automatic test_write_en;
    zg = 1; w = 1; dt_o = 16'h00A5; ad = 16'h0042;
    for (int i = 0; i < 10 && !bus_w; i++) @(negedge clk);
    checks++;
    if ({bus_w, bus_dt_o, bus_ad} !== {1'b1, 16'h00A5, 16'h0042}) begin failures++; $display("FAIL wr_strobe: w=%b dto=%h ad=%h want 1 00a5 0042", bus_w, bus_dt_o, bus_ad); end
    bus_en = 1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ren, rok, rpe, talarm, bus_w} !== 5'b10000) begin failures++; $display("FAIL wr_en: ren=%b rok=%b rpe=%b tal=%b w=%b want 1 0 0 0 0", ren, rok, rpe, talarm, bus_w); end
    zg = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ren, zw1, bus_rq} !== 3'b011) begin failures++; $display("FAIL wr_rel_hold: ren=%b zw1=%b rq=%b want 0 1 1", ren, zw1, bus_rq); end
    bus_en = 0;
    @(negedge clk);
    checks++;
    if ({zw1, bus_rq, bus_dt_o} !== 18'h0) begin failures++; $display("FAIL wr_idle: zw1=%b rq=%b dto=%h want 0 0 0000", zw1, bus_rq, bus_dt_o); end
    release_cycle();
  endtask
  task automatic test_timeout;
    int cnt;
    zg = 1; r = 1;
    for (int i = 0; i < 10 && !bus_r; i++) @(negedge clk);
    checks++;
    if (bus_r !== 1'b1) begin failures++; $display("FAIL to_strobe: r=%b want 1", bus_r); end
    cnt = 0;
    while (!talarm && cnt < 300) begin @(negedge clk); cnt++; end
    checks++;
    if (cnt != 250 || bus_r !== 1'b0 || rok !== 1'b0) begin failures++; $display("FAIL to_alarm: cycles=%0d r=%b rok=%b want 250 0 0", cnt, bus_r, rok); end
    zg = 0;
    @(negedge clk);
    checks++;
    if (talarm !== 1'b0) begin failures++; $display("FAIL to_clear: talarm=%b want 0", talarm); end
    release_cycle();
  endtask
  task automatic test_priority;
    zg = 1; r = 1;
    for (int i = 0; i < 10 && !bus_r; i++) @(negedge clk);
    bus_ok = 1; bus_pe = 1; bus_dt_i = 16'h5A5A;
    @(negedge clk);
    checks++;
    if ({rpe, rok, ren, talarm, dt_i} !== {4'b1000, 16'h5A5A}) begin failures++; $display("FAIL prio_rd: rpe=%b rok=%b ren=%b tal=%b dt_i=%h want 1 0 0 0 5a5a", rpe, rok, ren, talarm, dt_i); end
    release_cycle();
    zg = 1; w = 1; dt_o = 16'h1111;
    for (int i = 0; i < 10 && !bus_w; i++) @(negedge clk);
    bus_ok = 1; bus_pe = 1; bus_dt_i = 16'h7777;
    @(negedge clk);
    checks++;
    if ({rok, rpe, ren, talarm, dt_i} !== {4'b1000, 16'h5A5A}) begin failures++; $display("FAIL prio_wr: rok=%b rpe=%b ren=%b tal=%b dt_i=%h want 1 0 0 0 5a5a", rok, rpe, ren, talarm, dt_i); end
    release_cycle();
  endtask
  task automatic test_grant_abort;
    logic saw_zw1;
    bus_gnt = 0; zg = 1; r = 1; saw_zw1 = 0;
    repeat (10) begin @(negedge clk); saw_zw1 |= zw1; end
    checks++;
    if ({bus_rq, saw_zw1} !== 2'b10) begin failures++; $display("FAIL gnt_wait: rq=%b saw_zw1=%b want 1 0", bus_rq, saw_zw1); end
    zg = 0;
    @(negedge clk);
    saw_zw1 |= zw1;
    checks++;
    if ({bus_rq, saw_zw1} !== 2'b00) begin failures++; $display("FAIL gnt_abort: rq=%b saw_zw1=%b want 0 0", bus_rq, saw_zw1); end
    release_cycle();
  endtask
  task automatic test_bad_class;
    logic saw_strobe;
    bus_gnt = 1; zg = 1; r = 1; w = 1; saw_strobe = 0;
    repeat (4) begin @(negedge clk); saw_strobe |= bus_r | bus_w; end
    checks++;
    if ({talarm, rok, ren, rpe, saw_strobe, zw1} !== 6'b100001) begin failures++; $display("FAIL bad_class: tal=%b rok=%b ren=%b rpe=%b strobe=%b zw1=%b want 1 0 0 0 0 1", talarm, rok, ren, rpe, saw_strobe, zw1); end
    release_cycle();
  endtask
  task automatic test_reset_mid;
    zg = 1; w = 1; dt_o = 16'hC3C3; ad = 16'h0F0F;
    for (int i = 0; i < 10 && !bus_w; i++) @(negedge clk);
    #2 clo_n = 0;
    #1;
    checks++;
    if ({bus_w, bus_rq, zw1, bus_ad, bus_dt_o, dt_i} !== '0) begin failures++; $display("FAIL rst_mid: w=%b rq=%b zw1=%b ad=%h dto=%h dt_i=%h want all 0", bus_w, bus_rq, zw1, bus_ad, bus_dt_o, dt_i); end
    zg = 0; w = 0;
    @(negedge clk);
    clo_n = 1;
    @(negedge clk);
    zg = 1; r = 1; ad = 16'h2222;
    for (int i = 0; i < 10 && !bus_r; i++) @(negedge clk);
    bus_ok = 1; bus_dt_i = 16'h3C3C;
    @(negedge clk);
    checks++;
    if ({rok, bus_ad, dt_i} !== {1'b1, 16'h2222, 16'h3C3C}) begin failures++; $display("FAIL rst_recover: rok=%b ad=%h dt_i=%h want 1 2222 3c3c", rok, bus_ad, dt_i); end
    release_cycle();
  endtask
  initial begin
    test_reset();
    test_read_ok();
    test_write_en();
    test_timeout();
    test_priority();
    test_grant_abort();
    test_bad_class();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
